// File: rtl/alloc_pkg.sv
// Shared defaults and index types for the queue-slot allocator.
package alloc_pkg;

    localparam int ALLOC_NREQ   = 4;
    localparam int ALLOC_NSLOT  = 4;
    localparam int ALLOC_ID_W   = $clog2(ALLOC_NREQ);
    localparam int ALLOC_SLOT_W = $clog2(ALLOC_NSLOT);

    typedef logic [ALLOC_SLOT_W-1:0] slot_idx_t;
    typedef logic [ALLOC_ID_W-1:0]   req_idx_t;
    typedef logic [ALLOC_NSLOT-1:0]  slot_vec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int unsigned idx;
    logic        found;

    // Scan N positions starting at ptr; the first requesting one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
        any = found;
    end

endmodule

// File: rtl/alloc_arbiter.sv
// Round-robin allocator for the QValid slot pool with owner-checked release.
module alloc_arbiter
    import alloc_pkg::*;
#(
    parameter int NREQ   = ALLOC_NREQ,
    parameter int NSLOT  = ALLOC_NSLOT,
    parameter int ID_W   = $clog2(NREQ),
    parameter int SLOT_W = $clog2(NSLOT),
    parameter int CNT_W  = $clog2(NSLOT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [SLOT_W-1:0] gnt_slot,
    input  logic              rel,
    input  logic [SLOT_W-1:0] rel_slot,
    input  logic [ID_W-1:0]   rel_id,
    output logic [NSLOT-1:0]  QValid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  cnt,
    output logic              err
);

    logic [ID_W-1:0]   owner [NSLOT];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_next;

    logic [NREQ-1:0]   arb_gnt;
    logic [ID_W-1:0]   winner;
    logic              arb_any;
    logic              do_grant;

    logic              has_free;
    logic              rel_legal;
    logic [NSLOT-1:0]  qv_next;
    logic [CNT_W-1:0]  cnt_next;

    rr_arbiter #(
        .N  (NREQ),
        .PW (ID_W)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (winner),
        .any     (arb_any)
    );

    // A grant needs a requester, a free slot, and the block out of reset.
    always_comb begin
        do_grant = arb_any && !full && !rst;
        gnt      = do_grant ? arb_gnt : '0;
    end

    // Lowest-numbered free slot, scanned from the top so the lowest wins.
    always_comb begin
        gnt_slot = '0;
        has_free = 1'b0;
        for (int unsigned i = NSLOT; i > 0; i--) begin
            if (!QValid[i-1]) begin
                gnt_slot = SLOT_W'(i - 1);
                has_free = 1'b1;
            end
        end
    end

    // Release is legal only for an in-range, valid slot owned by rel_id;
    // the loop lookup makes out-of-range rel_slot fall through as illegal.
    always_comb begin
        rel_legal = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (rel && rel_slot == SLOT_W'(i) && QValid[i] && owner[i] == rel_id) begin
                rel_legal = 1'b1;
            end
        end
    end

    // Next slot-valid vector; granted slot is free and released slot is
    // valid, so the two updates never touch the same bit.
    always_comb begin
        qv_next = QValid;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (do_grant && gnt_slot == SLOT_W'(i)) begin
                qv_next[i] = 1'b1;
            end
            if (rel_legal && rel_slot == SLOT_W'(i)) begin
                qv_next[i] = 1'b0;
            end
        end
    end

    // Occupancy count: grant adds one, legal release removes one.
    always_comb begin
        cnt_next = cnt;
        if (do_grant && !rel_legal) begin
            cnt_next = cnt + 1'b1;
        end else if (!do_grant && rel_legal) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Pointer moves to the requester after the winner, wrapping at NREQ.
    always_comb begin
        if (winner == ID_W'(NREQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = winner + 1'b1;
        end
    end

    // Pool state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            QValid <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            err    <= 1'b0;
            rr_ptr <= '0;
        end else begin
            QValid <= qv_next;
            cnt    <= cnt_next;
            full   <= (cnt_next == CNT_W'(NSLOT));
            empty  <= (cnt_next == '0);
            err    <= rel && !rel_legal;
            if (do_grant) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

    // Owner table: record the winner against the slot it was handed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                owner[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (do_grant && gnt_slot == SLOT_W'(i)) begin
                    owner[i] <= winner;
                end
            end
        end
    end

endmodule

// File: doc/alloc_arbiter.md
# alloc_arbiter

Shares the 4-entry queue-slot pool (the per-slot `QValid` resource) between several requesters. Each cycle it picks one requester round-robin, hands it the lowest-numbered free slot, records which requester owns that slot, and frees slots on owner-checked release. It sits between the requesting engines and the queue storage, and is the only writer of the slot-valid vector.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (≥2).
- `NSLOT`, 4: number of slots (≥2).
- `ID_W`, `$clog2(NREQ)`: requester index width (derived).
- `SLOT_W`, `$clog2(NSLOT)`: slot index width (derived).

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req` input, `NREQ` bits: level request, one bit per requester.
- `gnt` output, `NREQ` bits: one-hot grant, combinational, valid in the same cycle as `req`.
- `gnt_slot` output, `SLOT_W` bits: slot index being granted; meaningful only while `|gnt`.
- `rel` input, 1 bit: release strobe.
- `rel_slot` input, `SLOT_W` bits: slot to free.
- `rel_id` input, `ID_W` bits: requester issuing the release.
- `QValid` output, `NSLOT` bits: registered slot-valid vector.
- `full` output, 1 bit: registered; all slots valid.
- `empty` output, 1 bit: registered; no slot valid.
- `cnt` output, `$clog2(NSLOT+1)` bits: registered count of valid slots.
- `err` output, 1 bit: registered one-cycle pulse on an illegal release.

## Operation
- State: `QValid`, an owner table (`NSLOT` × `ID_W`), the round-robin pointer `rr_ptr` (`ID_W` bits), `cnt`, and `err`.
- Grant:
  - When `|req` and `!full`, the arbiter grants exactly one requester. It picks the first set `req` bit searching upward from `rr_ptr` and wrapping modulo `NREQ`.
  - `gnt_slot` is the lowest index with `QValid == 0`.
  - On the clock edge: `QValid[gnt_slot] <= 1`, `owner[gnt_slot] <= winner`, and `rr_ptr <= (winner+1) mod NREQ`.
- Requester protocol:
  - A requester holds `req` until it sees `gnt`.
  - If `req` is still high on the cycle after a grant, that is a new request.
  - There is no ack; the grant is consumed at the edge.
- Full: `gnt = 0` and `rr_ptr` holds. Requests wait and are never dropped.
- Release:
  - A release is legal when `rel` is asserted, `QValid[rel_slot] == 1`, and `owner[rel_slot] == rel_id`. A legal release clears `QValid[rel_slot]` at the edge.
  - An illegal release (slot not valid, or owner mismatch) changes no state and produces `err = 1` for one cycle.
  - `rel_slot ≥ NSLOT` is illegal.
- Simultaneous grant and release:
  - Grant decisions use the pre-edge `QValid`, so a slot freed this cycle cannot be granted until the next cycle.
  - If the pool is full and a release arrives, there is no grant that cycle.
  - `cnt` next value = `cnt + grant − legal_release`, so a grant and a legal release in the same cycle leave `cnt` unchanged.
- `full` and `empty` are registered from the next-state count. They always match `cnt` in the same cycle.

## Timing
- Reset values (asynchronous assert): `QValid = 0`, owner table = 0, `rr_ptr = 0`, `cnt = 0`, `empty = 1`, `full = 0`, `err = 0`.
  - `gnt` is 0 while `rst` is high, regardless of `req`.
  - Reset arriving mid-operation discards all ownership; no release is needed afterwards.
- Grant latency:
  - `gnt` and `gnt_slot` are combinational on the cycle `req` is sampled (0 cycles).
  - `QValid`, `cnt`, `full`, and `empty` update 1 cycle later.
- Release latency: `QValid` clears 1 cycle after `rel`, and `err` pulses 1 cycle after `rel`. The freed slot is grantable 1 cycle after `rel`.
- Throughput: at most one grant and one release per cycle.

## Structure
- Package `alloc_pkg` holds:
  - default `NREQ`/`NSLOT` localparams;
  - typedefs `slot_idx_t` (`logic [SLOT_W-1:0]`), `req_idx_t` (`logic [ID_W-1:0]`) and `slot_vec_t`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational. `alloc_arbiter` owns `rr_ptr`.
- The free-slot priority encoder and owner table stay inline in `alloc_arbiter`.

## Test plan
- Reset then fill:
  - Stimulus: `rst` for 10 cycles, then hold `req = 4'b0001`.
  - Required: grants on 4 consecutive cycles with `gnt_slot` = 0, 1, 2, 3; `QValid` goes 0001 → 0011 → 0111 → 1111; `full = 1` and `cnt = 4` after the 4th edge; 5th cycle `gnt = 0`.
- Round-robin fairness:
  - Stimulus: from empty, hold `req = 4'b1111`.
  - Required: winners 0, 1, 2, 3 in order; owner table = {0, 1, 2, 3}.
- Release and reuse:
  - Stimulus: when full, `rel` on slot 2 with `rel_id = 2`.
  - Required: next cycle `QValid = 1011`, `cnt = 3`; a pending `req = 4'b0001` is then granted `gnt_slot = 2`.
- Illegal release:
  - Stimulus: `rel` on slot 1 with `rel_id = 3` (owner is 1); then `rel` on a free slot.
  - Required: `err` pulses 1 cycle each time; `QValid` unchanged.
- Simultaneous full release and request:
  - Stimulus: when full, legal `rel` on slot 0 plus `req = 4'b0100` in the same cycle.
  - Required: `gnt = 0` that cycle; next cycle `gnt = 4'b0100` with `gnt_slot = 0`; `cnt` goes 4 → 3 → 4.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously between edges with 3 slots held and `req` high.
  - Required: `QValid = 0`, `empty = 1`, `gnt = 0` immediately; after deassert, first grant goes to requester 0 / slot 0.
